// File: rtl/seq_normalizer.sv
// Multi-cycle leading-zero normalizer: one binary-search stage per cycle, valid/ready on both sides.
// Define SEQ_NORM_SIGNED_EN to add the signed_mode input (redundant-sign-bit normalization).
module seq_normalizer #(
   parameter int W     = 8,
   parameter int LOG2W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
`ifdef SEQ_NORM_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [LOG2W-1:0] out_shamt,
   output logic             out_zero
);

   localparam int SW = (LOG2W > 1) ? $clog2(LOG2W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     data_q, data_d;
   logic [LOG2W-1:0] shamt_q, shamt_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic             zero_q, zero_d;
`ifdef SEQ_NORM_SIGNED_EN
   logic             signed_q, signed_d;
`endif

   // Per-stage candidate: shift amount k=2^gi, the shifted operand and whether the shift is legal.
   logic [W-1:0]     shifted   [LOG2W];
   logic [LOG2W-1:0] step_amt  [LOG2W];
   logic [LOG2W-1:0] stage_hit;

   generate
      for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
         localparam int K = 2 ** gi;
         logic top_zero;
         assign top_zero      = ~|data_q[W-1 -: K];
         assign shifted[gi]   = data_q << K;
         assign step_amt[gi]  = LOG2W'(K);
`ifdef SEQ_NORM_SIGNED_EN
         // Signed: the top K+1 bits are all copies of the sign, so K of them are redundant.
         logic top_same;
         assign top_same      = (&data_q[W-1 -: K+1]) | ~(|data_q[W-1 -: K+1]);
         assign stage_hit[gi] = signed_q ? top_same : top_zero;
`else
         assign stage_hit[gi] = top_zero;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         data_q   <= '0;
         shamt_q  <= '0;
         stage_q  <= '0;
         zero_q   <= 1'b0;
`ifdef SEQ_NORM_SIGNED_EN
         signed_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         shamt_q  <= shamt_d;
         stage_q  <= stage_d;
         zero_q   <= zero_d;
`ifdef SEQ_NORM_SIGNED_EN
         signed_q <= signed_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      shamt_d  = shamt_q;
      stage_d  = stage_q;
      zero_d   = zero_q;
`ifdef SEQ_NORM_SIGNED_EN
      signed_d = signed_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d   = in_data;
               shamt_d  = '0;
               stage_d  = SW'(LOG2W - 1);
               zero_d   = (in_data == '0);
`ifdef SEQ_NORM_SIGNED_EN
               signed_d = signed_mode;
`endif
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            for (int i = 0; i < LOG2W; i++) begin
               if (stage_q == SW'(i) && stage_hit[i]) begin
                  data_d  = shifted[i];
                  shamt_d = shamt_q + step_amt[i];
               end
            end
            if (stage_q == '0) begin
               state_d = DONE;
            end else begin
               stage_d = stage_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready is masked by rst so nothing is handshaken during a reset cycle.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign out_data  = data_q;
   assign out_shamt = shamt_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a leading-zero / leading-sign-bit reference model.
`timescale 1ns/1ps
module tb_seq_normalizer;
   localparam int W     = 8;
   localparam int LOG2W = 3;
   localparam int NRAND = 1000;
`ifdef SEQ_NORM_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             signed_mode = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_data;
   logic [LOG2W-1:0] out_shamt;
   logic             out_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_normalizer #(.W(W), .LOG2W(LOG2W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
`ifdef SEQ_NORM_SIGNED_EN
      .signed_mode(signed_mode),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_shamt  (out_shamt),
      .out_zero   (out_zero)
   );

   typedef struct {
      logic [W-1:0]     din;
      logic             sm;
      logic [W-1:0]     dout;
      logic [LOG2W-1:0] shamt;
      logic             zero;
   } vec_t;

   typedef struct {
      logic [W-1:0] din;
      logic         sm;
   } exp_t;

   vec_t vecs[$];
   exp_t expq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: count leading zeros (or redundant sign bits) by scanning bits from the MSB.
   function automatic void ref_norm(input logic [W-1:0] d, input logic sm,
                                    output logic [W-1:0] od, output logic [LOG2W-1:0] os,
                                    output logic oz);
      int n;
      n = 0;
      if (sm && SIGNED_BUILD) begin
         for (int i = W - 2; i >= 0; i--) begin
            if (d[i] != d[W-1]) break;
            n++;
         end
      end else begin
         for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) break;
            n++;
         end
         if (n > W - 1) n = W - 1;
      end
      os = LOG2W'(n);
      od = d << n;
      oz = (d == '0);
   endfunction

   // Called just after a negedge; returns just after a negedge with the result consumed.
   task automatic do_op(input logic [W-1:0] d, input logic sm, output logic [W-1:0] od,
                        output logic [LOG2W-1:0] os, output logic oz, output int lat);
      int n;
      in_valid = 1'b1; in_data = d; signed_mode = sm; n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      if (!in_ready) begin
         in_valid = 1'b0; lat = -1; od = '0; os = '0; oz = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      if (!out_valid) lat = -1;
      od = out_data; os = out_shamt; oz = out_zero;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0]     od;
      logic [LOG2W-1:0] os;
      logic             oz;
      int               lat;
      int               n;
      int               received;
      int               cycles;
      bit               drv_abort;

      // Directed vectors: {in, signed_mode, expected data, shamt, zero}
      vecs.push_back('{8'h13, 1'b0, 8'h98, 3'd3, 1'b0});
      vecs.push_back('{8'h00, 1'b0, 8'h00, 3'd7, 1'b1});
      vecs.push_back('{8'h80, 1'b0, 8'h80, 3'd0, 1'b0});
      vecs.push_back('{8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0});
      vecs.push_back('{8'h01, 1'b0, 8'h80, 3'd7, 1'b0});
      vecs.push_back('{8'h40, 1'b0, 8'h80, 3'd1, 1'b0});
      vecs.push_back('{8'h0A, 1'b0, 8'hA0, 3'd4, 1'b0});
`ifdef SEQ_NORM_SIGNED_EN
      vecs.push_back('{8'h05, 1'b1, 8'h50, 3'd4, 1'b0});
      vecs.push_back('{8'hF3, 1'b1, 8'h98, 3'd3, 1'b0});
      vecs.push_back('{8'hFF, 1'b1, 8'h80, 3'd7, 1'b0});
      vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd7, 1'b1});
      vecs.push_back('{8'h80, 1'b1, 8'h80, 3'd0, 1'b0});
      vecs.push_back('{8'h05, 1'b0, 8'hA0, 3'd5, 1'b0});
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_shamt", 32'(out_shamt), 32'd0);
      check("rst_out_zero",  32'(out_zero),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Table-driven directed vectors
      foreach (vecs[i]) begin
         do_op(vecs[i].din, vecs[i].sm, od, os, oz, lat);
         $display("vec %0d: in=%02h sm=%0d -> data=%02h shamt=%0d zero=%0d lat=%0d",
                  i, vecs[i].din, vecs[i].sm, od, os, oz, lat);
         check("vec_latency", 32'(lat), 32'(LOG2W + 1));
         check("vec_data",    32'(od),  32'(vecs[i].dout));
         check("vec_shamt",   32'(os),  32'(vecs[i].shamt));
         check("vec_zero",    32'(oz),  32'(vecs[i].zero));
      end

      // Backpressure: result held while a new operand waits on in_valid
      in_valid = 1'b1; in_data = 8'h13; signed_mode = 1'b0;
      @(negedge clk);
      in_data = 8'h55;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("bp_out_valid_seen", 32'(out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data",  32'(out_data),  32'h98);
         check("bp_hold_shamt", 32'(out_shamt), 32'd3);
         check("bp_in_ready",   32'(in_ready),  32'd0);
         @(negedge clk);
      end
      $display("bp: in=13 held 5 cycles -> data=%02h shamt=%0d", out_data, out_shamt);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_in_ready",  32'(in_ready),  32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      $display("bp: waiting in=55 -> data=%02h shamt=%0d", out_data, out_shamt);
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_data",  32'(out_data),  32'hAA);
      check("bp_next_shamt", 32'(out_shamt), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Back-to-back operands
      do_op(8'h01, 1'b0, od, os, oz, lat);
      $display("b2b: in=01 -> data=%02h shamt=%0d", od, os);
      check("b2b0_shamt", 32'(os), 32'd7);
      do_op(8'h40, 1'b0, od, os, oz, lat);
      $display("b2b: in=40 -> data=%02h shamt=%0d", od, os);
      check("b2b1_shamt", 32'(os), 32'd1);
      check("b2b1_data",  32'(od), 32'h80);

      // Reset in the second SHIFT cycle discards the operand
      in_valid = 1'b1; in_data = 8'h01;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data",  32'(out_data),  32'd0);
      check("mid_rst_out_shamt", 32'(out_shamt), 32'd0);
      check("mid_rst_out_zero",  32'(out_zero),  32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_idle", 32'(in_ready), 32'd1);
      do_op(8'h20, 1'b0, od, os, oz, lat);
      $display("post-rst: in=20 -> data=%02h shamt=%0d", od, os);
      check("post_rst_data",  32'(od), 32'h80);
      check("post_rst_shamt", 32'(os), 32'd2);
      check("post_rst_lat",   32'(lat), 32'(LOG2W + 1));

      // Randomized traffic with random valid and ready gaps
      received  = 0;
      cycles    = 0;
      drv_abort = 1'b0;
      fork
         begin : driver
            for (int i = 0; i < NRAND && !drv_abort; i++) begin
               int gap;
               int to;
               gap = $urandom_range(0, 3);
               repeat (gap) @(negedge clk);
               in_valid = 1'b1;
               in_data = W'($urandom);
               signed_mode = 1'($urandom);
               to = 0;
               while (!in_ready && to < 100) begin @(negedge clk); to++; end
               if (!in_ready) begin
                  total++; bad++;
                  $display("FAIL rand_accept_timeout: op %0d not accepted, expected accept", i);
                  drv_abort = 1'b1;
               end else begin
                  expq.push_back('{in_data, signed_mode});
                  @(negedge clk);
               end
               in_valid = 1'b0;
            end
         end
         begin : monitor
            while (received < NRAND && cycles < 40000 && !drv_abort) begin
               @(negedge clk);
               cycles++;
               out_ready = ($urandom_range(0, 9) < 7);
               if (out_valid && out_ready) begin
                  exp_t e;
                  logic [W-1:0]     ed;
                  logic [LOG2W-1:0] es;
                  logic             ez;
                  if (expq.size() == 0) begin
                     total++; bad++;
                     $display("FAIL rand_extra_result: got data=%02h, expected none", out_data);
                  end else begin
                     e = expq.pop_front();
                     ref_norm(e.din, e.sm, ed, es, ez);
                     $display("rand %0d: in=%02h sm=%0d -> data=%02h shamt=%0d zero=%0d",
                              received, e.din, e.sm, out_data, out_shamt, out_zero);
                     check("rand_data",  32'(out_data),  32'(ed));
                     check("rand_shamt", 32'(out_shamt), 32'(es));
                     check("rand_zero",  32'(out_zero),  32'(ez));
                  end
                  received++;
               end
            end
            @(negedge clk);
            out_ready = 1'b0;
         end
      join
      check("rand_received", 32'(received), 32'(NRAND));
      check("rand_queue_empty", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
